// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle execute-stage ALU: opcode map,
// controller state encoding and the default datapath width.
package alu_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_DIV  = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1101;
    localparam logic [3:0] OP_REM  = 4'b1110;
    localparam logic [3:0] OP_REMU = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic is_mul_op(input logic [3:0] op);
        return op == OP_MUL;
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    // Signed variants of divide/remainder need magnitude pre-correction.
    function automatic logic is_signed_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_rem_op(input logic [3:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply / divide engine. One bit per step: shift-add for MUL,
// restoring division on operand magnitudes for DIV/DIVU/REM/REMU, with the
// sign fix-up applied on the way out. Sequenced by load/step/finish strobes.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic            finish,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            last,
    output logic [XLEN-1:0] result
);

    localparam int            CW       = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    logic [CW-1:0]   cnt;
    logic            mode_mul;
    logic            mode_rem;
    logic            neg_q;
    logic            neg_r;
    // acc: product accumulator (MUL) or partial remainder (DIV)
    // opa: shifting multiplicand (MUL) or divisor magnitude (DIV)
    // opb: shifting multiplier (MUL) or dividend-in / quotient-out (DIV)
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic [XLEN-1:0] acc_n;
    logic [XLEN-1:0] opa_n;
    logic [XLEN-1:0] opb_n;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   rem_diff;
    logic            rem_ge;
    logic            op_signed;

    // Two's-complement magnitude; -2^(XLEN-1) maps to 2^(XLEN-1) unsigned.
    function automatic logic [XLEN-1:0] magnitude(input logic signed [XLEN-1:0] x,
                                                  input logic sgn);
        logic signed [XLEN-1:0] negx;
        negx = -x;
        return (sgn && x[XLEN-1]) ? negx : x;
    endfunction

    function automatic logic [XLEN-1:0] apply_sign(input logic signed [XLEN-1:0] mag,
                                                   input logic neg);
        logic signed [XLEN-1:0] negm;
        negm = -mag;
        return neg ? negm : mag;
    endfunction

    assign op_signed = is_signed_div_op(op);
    assign last      = (cnt == CNT_LAST);

    // One iteration of either datapath, plus the sign-corrected result as it
    // will be after this step (captured by the top on the final step).
    always_comb begin
        rem_sh   = {acc, opb[XLEN-1]};
        rem_diff = rem_sh - {1'b0, opa};
        rem_ge   = ~rem_diff[XLEN];
        if (mode_mul) begin
            acc_n = acc + (opb[0] ? opa : '0);
            opa_n = opa << 1;
            opb_n = opb >> 1;
        end else begin
            acc_n = rem_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
            opa_n = opa;
            opb_n = {opb[XLEN-2:0], rem_ge};
        end
        if (mode_mul) begin
            result = acc_n;
        end else if (mode_rem) begin
            result = apply_sign(acc_n, neg_r);
        end else begin
            result = apply_sign(opb_n, neg_q);
        end
    end

    // Iteration counter: cleared on load and after the final step.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load || finish) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Operand latch and per-step datapath update. A zero divisor never
    // flips the quotient sign so it stays all ones; the remainder keeps
    // the dividend's sign so it equals the dividend.
    always_ff @(posedge clk) begin
        if (load) begin
            mode_mul <= is_mul_op(op);
            mode_rem <= is_rem_op(op);
            neg_q    <= op_signed && (a[XLEN-1] ^ b[XLEN-1]) && (b != '0);
            neg_r    <= op_signed && a[XLEN-1];
            acc      <= '0;
            if (is_mul_op(op)) begin
                opa <= a;
                opb <= b;
            end else begin
                opa <= magnitude(b, op_signed);
                opb <= magnitude(a, op_signed);
            end
        end else if (step) begin
            acc <= acc_n;
            opa <= opa_n;
            opb <= opb_n;
        end
    end

endmodule

// File: rtl/alu_md.sv
// Multi-cycle execute-stage ALU. Basic ops finish in one cycle; MUL and the
// divide family run through alu_muldiv_iter for XLEN steps while busy is high.
module alu_md
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [3:0]      alucontrol,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic [XLEN-1:0] inimm,
    input  logic            alusrc,
    output logic [XLEN-1:0] out,
    output logic            zero,
    output logic            busy,
    output logic            done
);

    state_t          state_q;
    state_t          state_d;
    logic [XLEN-1:0] opb;
    logic [XLEN-1:0] iter_result;
    logic            iter_op;
    logic            accept;
    logic            load;
    logic            step;
    logic            finish;
    logic            last;

    function automatic logic [XLEN-1:0] alu_basic(input logic [3:0] op,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        sa = a;
        sb = b;
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLT:  return {{(XLEN-1){1'b0}}, (sa < sb)};
            default: return '0;
        endcase
    endfunction

    assign opb     = alusrc ? inimm : in2;
    assign iter_op = is_mul_op(alucontrol) || is_div_op(alucontrol);
    assign accept  = (state_q == S_IDLE) && start;
    assign zero    = (out == '0);

    alu_muldiv_iter #(
        .XLEN(XLEN)
    ) u_iter (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .step  (step),
        .finish(finish),
        .op    (alucontrol),
        .a     (in1),
        .b     (opb),
        .last  (last),
        .result(iter_result)
    );

    // Controller state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: starts are only honoured in IDLE, DONE always returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_mul_op(alucontrol)) begin
                        state_d = S_MUL;
                    end else if (is_div_op(alucontrol)) begin
                        state_d = S_DIV;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs and strobes for the iterative engine.
    always_comb begin
        busy   = (state_q == S_MUL) || (state_q == S_DIV);
        done   = (state_q == S_DONE);
        load   = accept && iter_op;
        step   = busy;
        finish = busy && last;
    end

    // Result register: basic ops land at the accepting edge, iterative ops
    // on their final step; otherwise the previous result is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            out <= '0;
        end else if (accept && !iter_op) begin
            out <= alu_basic(alucontrol, in1, opb);
        end else if (finish) begin
            out <= iter_result;
        end
    end

endmodule

// File: doc/alu_md.md
# alu_md

Multi-cycle, parametrised successor to the single-cycle datapath ALU. It adds the RISC-V M-extension operations MUL, DIV, DIVU, REM and REMU, computed iteratively, on top of the AND/OR/ADD/SUB/SLT set. A start/busy/done handshake lets the control FSM stall the pipeline while a long operation is in flight. The block sits in the execute stage, in place of the combinational ALU.

## Interface
- XLEN, 32: operand and result width (≥ 8).
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- alucontrol  in  4  operation code, sampled with start.
- in1  in  XLEN  operand A, sampled with start.
- in2  in  XLEN  register operand B.
- inimm  in  XLEN  immediate operand B.
- alusrc  in  1  1: operand B = inimm; 0: operand B = in2.
- out  out  XLEN  registered result; holds its value until the next done.
- zero  out  1  (out == 0), decoded from the registered out.
- busy  out  1  an iterative operation is in progress.
- done  out  1  one-cycle pulse; out is valid in this cycle.

## Operation
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1000 SLT (signed, result 0/1).
  - 1010 MUL (low XLEN bits), 1100 DIV, 1101 DIVU, 1110 REM, 1111 REMU.
  - Any other code: out=0.
- Operands A and B are latched at the accepted start. Later changes to the inputs do not affect the operation in flight.
- States:
  - IDLE: waiting for start.
  - MUL: shift-add multiply.
  - DIV: restoring divide.
  - DONE: asserts done.
- Transitions:
  - IDLE, start, basic or undefined opcode: result registered at that edge → DONE.
  - IDLE, start, MUL → MUL. IDLE, start, DIV/DIVU/REM/REMU → DIV.
  - MUL or DIV: one iteration per cycle. Iteration counter counts 0..XLEN-1, then → DONE.
  - DONE: done=1 → IDLE. A start in this cycle is ignored.
- MUL: shift-add over the raw bit patterns. The low XLEN bits are identical for signed and unsigned operands.
- Signed DIV/REM:
  - Divide the operand magnitudes unsigned.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Divide by zero (any of the four ops): quotient = all ones; remainder = dividend. Takes the full XLEN iterations.
- Signed overflow (-2^(XLEN-1) / -1): quotient = dividend, remainder = 0.
- start while busy=1 or in DONE: ignored, with no queueing.
- All adders and subtractors wrap modulo 2^XLEN. The divider partial remainder is XLEN+1 bits wide.

## Timing
- Reset values: out=0, zero=1, busy=0, done=0, state=IDLE, counter=0.
- Reset mid-operation aborts the operation. All outputs take their reset values on the next edge and no done is produced.
- Basic or undefined op accepted at edge 0: done=1 and out valid in cycle 1. Latency 1, busy never asserted.
- Iterative op accepted at edge 0:
  - busy=1 in cycles 1..XLEN.
  - done=1, busy=0, out valid in cycle XLEN+1 (cycle 33 for XLEN=32).
- Earliest next accept is the cycle after done (back-to-back rate: 2 cycles basic, XLEN+2 cycles iterative).
- busy and done are never high in the same cycle.

## Structure
- Package alu_pkg holds:
  - the opcode constants;
  - the state encoding (IDLE, MUL, DIV, DONE);
  - XLEN default.
- The core ALU, mode/exception handling and output register are implemented in alu_md itself.
- Sub-module alu_muldiv_iter contains:
  - the iteration counter;
  - the shift-add and restoring datapaths;
  - sign pre- and post-correction.
- alu_muldiv_iter is controlled by alu_md's FSM through load/step/finish strobes.

## Test plan
- ADD, in1=5, in2=9, alusrc=0 → cycle 1: out=14, zero=0, done=1, busy=0 throughout.
- SUB, in1=5, inimm=20, alusrc=1 → out=0xFFFFFFF1. SLT on the same operands → out=1. AND 5,9 → out=1. SUB 9-9 → zero=1.
- MUL, in1=7, in2=0xFFFFFFFD → busy in cycles 1–32, done in cycle 33, out=0xFFFFFFEB. A start with ADD 1+1 issued in cycle 5 is ignored and out does not become 2.
- DIV -20/3 → 0xFFFFFFFA; REM -20/3 → 0xFFFFFFFE; DIVU 20/3 → 6; REMU 20/3 → 2.
- DIVU 10/0 → 0xFFFFFFFF; REMU 10/0 → 10; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0. Each completes in cycle 33.
- Reset asserted in cycle 10 of a MUL → next cycle out=0, zero=1, busy=0, and no done follows. ADD 2+3 started afterwards gives out=5 after 1 cycle.
